// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and defaults for the load/store unit
package lsu_pkg;

    localparam int LSU_DEPTH = 128;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extraction with extension for loads, lane merge for stores
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = word[{lane, 3'b000} +: 8];
        half_val = word[{lane[1], 4'b0000} +: 16];

        case (size)
            SZ_BYTE: load_data = {{24{is_signed & byte_val[7]}}, byte_val};
            SZ_HALF: load_data = {{16{is_signed & half_val[15]}}, half_val};
            default: load_data = word;
        endcase

        // Sub-word stores keep every bit outside the addressed lane.
        merged = word;
        case (size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store front end for a single-port word memory
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = LSU_DEPTH,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_address,
    output logic [31:0]   mem_data_in,
    output logic          mem_RW,
    input  logic [31:0]   mem_data_out
);

    localparam logic [AW-1:0] ADDR_LIMIT = AW'(DEPTH * 4);

    lsu_state_t    state_q, state_d;
    logic [1:0]    lane_q, size_q;
    logic          we_q, signed_q;
    logic [31:0]   wdata_q;

    logic          req_err;
    logic          accept;
    logic [31:0]   load_data, merged_data;

    logic          mem_rw_d;
    logic [AW-1:0] mem_address_d;
    logic [31:0]   mem_data_in_d, rdata_d;
    logic          err_d;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign accept     = req_valid && req_ready;

    always_comb begin
        case (req_size)
            SZ_BYTE: req_err = 1'b0;
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (req_addr >= ADDR_LIMIT) req_err = 1'b1;
    end

    lsu_align u_align (
        .word      (mem_data_out),
        .lane      (lane_q),
        .size      (size_q),
        .is_signed (signed_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Memory-side outputs are computed one cycle ahead so they come straight from flops.
    always_comb begin
        state_d       = state_q;
        mem_rw_d      = 1'b0;
        mem_address_d = mem_address;
        mem_data_in_d = mem_data_in;
        rdata_d       = resp_rdata;
        err_d         = resp_err;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    if (req_err) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        mem_address_d = {2'b00, req_addr[AW-1:2]};
                        if (req_we && req_size == SZ_WORD) begin
                            mem_rw_d      = 1'b1;
                            mem_data_in_d = req_wdata;
                            state_d       = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    mem_rw_d      = 1'b1;
                    mem_data_in_d = merged_data;
                    state_d       = WRITE;
                end else begin
                    rdata_d = load_data;
                    state_d = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_RW      <= 1'b0;
            mem_address <= '0;
            mem_data_in <= 32'h0;
            resp_rdata  <= 32'h0;
            resp_err    <= 1'b0;
            lane_q      <= 2'b00;
            size_q      <= SZ_BYTE;
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            wdata_q     <= 32'h0;
        end else begin
            mem_RW      <= mem_rw_d;
            mem_address <= mem_address_d;
            mem_data_in <= mem_data_in_d;
            resp_rdata  <= rdata_d;
            resp_err    <= err_d;
            if (accept) begin
                lane_q   <= req_addr[1:0];
                size_q   <= req_size;
                we_q     <= req_we;
                signed_q <= req_signed;
                wdata_q  <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_RW;
    logic [31:0] mem_data_out;

    logic [31:0] mem [0:127];
    int          wr_cnt = 0;
    logic [31:0] last_wr_addr = 32'h0;
    logic [31:0] last_wr_data = 32'h0;
    int          tests = 0;
    int          fails = 0;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_RW       (mem_RW),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_address[6:0]];

    always @(posedge clk) begin
        if (mem_RW) begin
            mem[mem_address[6:0]] <= mem_data_in;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_address;
            last_wr_data <= mem_data_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_addr   = addr;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_wdata  = wdata;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_req(input string tag, input logic [31:0] addr, input logic we,
                          input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_wr, input logic [31:0] exp_wr_data);
        int lat;
        int wr0;
        logic first_rw;
        @(negedge clk);
        check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
        drive(addr, we, size, sgn, wdata);
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        first_rw = mem_RW;
        wait_resp(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " err"}, {31'h0, resp_err}, {31'h0, exp_err});
        check({tag, " writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        check({tag, " first cycle rw"}, {31'h0, first_rw},
              {31'h0, (exp_wr > 0) && (exp_lat == 2)});
        if (exp_wr > 0) begin
            check({tag, " wr addr"}, last_wr_addr, {2'b00, addr[31:2]});
            check({tag, " wr data"}, last_wr_data, exp_wr_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;

        #12;
        check("reset req_ready", {31'h0, req_ready}, 32'h1);
        check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        check("reset resp_err", {31'h0, resp_err}, 32'h0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset mem_RW", {31'h0, mem_RW}, 32'h0);
        check("reset mem_address", mem_address, 32'h0);
        check("reset mem_data_in", mem_data_in, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        //     tag            addr      we    size   sgn   wdata         lat rdata         err   wr wr_data
        do_req("sw 0x10",     32'h10,  1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 2, 32'h0,        1'b0, 1, 32'hDEADBEEF);
        do_req("lw 0x10",     32'h10,  1'b0, 2'b10, 1'b0, 32'h0,        2, 32'hDEADBEEF, 1'b0, 0, 32'h0);
        do_req("lb 0x13",     32'h13,  1'b0, 2'b00, 1'b1, 32'h0,        2, 32'hFFFFFFDE, 1'b0, 0, 32'h0);
        do_req("lbu 0x13",    32'h13,  1'b0, 2'b00, 1'b0, 32'h0,        2, 32'h000000DE, 1'b0, 0, 32'h0);
        do_req("lh 0x12",     32'h12,  1'b0, 2'b01, 1'b1, 32'h0,        2, 32'hFFFFDEAD, 1'b0, 0, 32'h0);
        do_req("lb 0x10",     32'h10,  1'b0, 2'b00, 1'b1, 32'h0,        2, 32'hFFFFFFEF, 1'b0, 0, 32'h0);
        do_req("sb 0x11",     32'h11,  1'b1, 2'b00, 1'b0, 32'hFFFFFF55, 3, 32'h0,        1'b0, 1, 32'hDEAD55EF);
        do_req("lw after sb", 32'h10,  1'b0, 2'b10, 1'b0, 32'h0,        2, 32'hDEAD55EF, 1'b0, 0, 32'h0);
        do_req("sh 0x12",     32'h12,  1'b1, 2'b01, 1'b0, 32'h1234ABCD, 3, 32'h0,        1'b0, 1, 32'hABCD55EF);
        do_req("lhu 0x10",    32'h10,  1'b0, 2'b01, 1'b0, 32'h0,        2, 32'h000055EF, 1'b0, 0, 32'h0);
        do_req("err lh 0x11", 32'h11,  1'b0, 2'b01, 1'b1, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0);
        do_req("err sw 0x12", 32'h12,  1'b1, 2'b10, 1'b0, 32'h11111111, 1, 32'h0,        1'b1, 0, 32'h0);
        do_req("err size 11", 32'h10,  1'b0, 2'b11, 1'b0, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0);
        do_req("err 0x200",   32'h200, 1'b1, 2'b10, 1'b0, 32'h22222222, 1, 32'h0,        1'b1, 0, 32'h0);
        do_req("sw word 127", 32'h1FC, 1'b1, 2'b10, 1'b0, 32'h12345678, 2, 32'h0,        1'b0, 1, 32'h12345678);
        do_req("lhu 0x1FE",   32'h1FE, 1'b0, 2'b01, 1'b0, 32'h0,        2, 32'h00001234, 1'b0, 0, 32'h0);
        do_req("sb word 0",   32'h0,   1'b1, 2'b00, 1'b0, 32'h000000A5, 3, 32'h0,        1'b0, 1, 32'h000000A5);
        do_req("lb word 0",   32'h0,   1'b0, 2'b00, 1'b1, 32'h0,        2, 32'hFFFFFFA5, 1'b0, 0, 32'h0);
        check("word 4 untouched by errors", mem[4], 32'hABCD55EF);

        // Backpressure: response held for 5 cycles, then a queued request follows.
        @(negedge clk);
        resp_ready = 1'b0;
        drive(32'h10, 1'b0, 2'b10, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_resp(lat);
        check("bp latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp resp_valid", {31'h0, resp_valid}, 32'h1);
            check("bp rdata", resp_rdata, 32'hABCD55EF);
            check("bp req_ready", {31'h0, req_ready}, 32'h0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        drive(32'h13, 1'b0, 2'b00, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("bp back to idle", {31'h0, req_ready}, 32'h1);
        check("bp resp dropped", {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp next accepted", {31'h0, req_ready}, 32'h0);
        wait_resp(lat);
        check("bp next latency", 32'(lat), 32'd2);
        check("bp next rdata", resp_rdata, 32'h000000AB);
        @(posedge clk);
        #1;

        // Reset while a sub-word store sits in READ.
        do_req("sw word 5", 32'h14, 1'b1, 2'b10, 1'b0, 32'h11223344, 2, 32'h0, 1'b0, 1, 32'h11223344);
        @(negedge clk);
        drive(32'h14, 1'b1, 2'b00, 1'b0, 32'h000000AA);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mem_RW", {31'h0, mem_RW}, 32'h0);
        check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post rst resp_valid", {31'h0, resp_valid}, 32'h0);
        check("post rst req_ready", {31'h0, req_ready}, 32'h1);
        check("post rst word 5", mem[5], 32'h11223344);
        do_req("lw word 5", 32'h14, 1'b0, 2'b10, 1'b0, 32'h0, 2, 32'h11223344, 1'b0, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
